// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo front end: instruction layout,
// opcode encodings, unit selects and the issue-queue state type.
package tomasulo_pkg;

  localparam int INST_W = 9;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RD_MSB = 5;
  localparam int RD_LSB = 4;
  localparam int RS_MSB = 3;
  localparam int RS_LSB = 2;
  localparam int RT_MSB = 1;
  localparam int RT_LSB = 0;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic UNIT_ADD = 1'b0;
  localparam logic UNIT_MUL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } iq_state_t;

  // Only arithmetic opcodes occupy a FIFO slot; HALT and the NOP encodings are dropped.
  function automatic logic op_is_issuable(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic op_unit(input logic [2:0] op);
    return ((op == OP_MUL) || (op == OP_DIV)) ? UNIT_MUL : UNIT_ADD;
  endfunction

endpackage

// File: rtl/instr_rom.sv
// Writable program store: synchronous write port, asynchronous read port.
// Contents deliberately survive reset.
module instr_rom
  import tomasulo_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  localparam int AW = $clog2(PROG_DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [PROG_DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issue_queue.sv
// In-order fetch/issue front end: fetches program words into a small FIFO
// and hands the head to the add or mult reservation-station group.
module instr_issue_queue
  import tomasulo_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 8,
  localparam int PC_W  = $clog2(PROG_DEPTH),
  localparam int FC_W  = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [INST_W-1:0] prog_data,
  input  logic              start,
  input  logic              add_full,
  input  logic              mult_full,
  output logic              issue_valid,
  output logic [INST_W-1:0] issue_inst,
  output logic              issue_unit,
  output logic [PC_W-1:0]   pc,
  output logic [FC_W-1:0]   fifo_count,
  output logic [CNT_W-1:0]  issued,
  output logic              running,
  output logic              halted
);

  iq_state_t         state, state_next;
  logic [PC_W-1:0]   pc_q;
  logic [FC_W-1:0]   count, count_next;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  issued_q;
  logic [INST_W-1:0] fifo_mem [DEPTH];
  logic [INST_W-1:0] rom_data, head;
  logic [2:0]        fetch_op;
  logic              parked, start_run, rom_we, fetch, push, pop;
  logic              nonempty, head_unit, head_blocked, last_addr;

  instr_rom #(.PROG_DEPTH(PROG_DEPTH)) u_rom (
    .clock (clock),
    .we    (rom_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (rom_data)
  );

  assign parked    = (state == ST_IDLE) || (state == ST_HALT);
  assign start_run = parked && start;
  assign rom_we    = parked && prog_we;
  assign running   = (state == ST_RUN) || (state == ST_DRAIN);
  assign halted    = (state == ST_HALT);

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot for fetch.
  assign fetch     = (state == ST_RUN) && (count != FC_W'(DEPTH));
  assign fetch_op  = rom_data[OP_MSB:OP_LSB];
  assign push      = fetch && op_is_issuable(fetch_op);
  assign last_addr = (pc_q == PC_W'(PROG_DEPTH - 1));

  assign nonempty     = (count != '0);
  assign head         = fifo_mem[rd_ptr];
  assign head_unit    = op_unit(head[OP_MSB:OP_LSB]);
  assign head_blocked = (head_unit == UNIT_MUL) ? mult_full : add_full;
  assign pop          = reset_n && running && nonempty && !head_blocked;

  assign issue_valid = pop;
  assign issue_inst  = nonempty ? head : '0;
  assign issue_unit  = nonempty ? head_unit : UNIT_ADD;
  assign pc          = pc_q;
  assign fifo_count  = count;
  assign issued      = issued_q;

  always_comb begin
    state_next = state;
    count_next = count + FC_W'(push) - FC_W'(pop);
    case (state)
      ST_IDLE, ST_HALT: if (start) state_next = ST_RUN;
      ST_RUN:   if (fetch && ((fetch_op == OP_HALT) || last_addr)) state_next = ST_DRAIN;
      ST_DRAIN: if (count_next == '0) state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      pc_q     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      issued_q <= '0;
    end else begin
      state <= state_next;
      if (start_run) begin
        pc_q     <= '0;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        issued_q <= '0;
      end else begin
        count <= count_next;
        if (fetch && !last_addr) pc_q <= pc_q + PC_W'(1);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          if (issued_q != '1) issued_q <= issued_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= rom_data;
  end

endmodule

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
- In-order fetch-and-issue front end that sits directly upstream of the Tomasulo control block and feeds it 9-bit instructions.
- Holds a small writable program memory and fetches from it in program order into a DEPTH-entry FIFO.
- Issues the FIFO head to the add or mult reservation-station group, but only while that group's full flag is low.
- Exposes PC, occupancy and issue count for LEDs and seven-segment display.

Parameters:
- PROG_DEPTH, 16, program memory words; PC width is clog2(PROG_DEPTH).
- DEPTH, 4, FIFO entries (power of two).
- CNT_W, 8, width of the issued-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- prog_we  in  1  program-memory write strobe; honoured only in IDLE or HALT.
- prog_addr  in  clog2(PROG_DEPTH)  program write address.
- prog_data  in  9  program write data.
- start  in  1  one-cycle pulse: begin execution from address 0.
- add_full  in  1  add reservation stations full (back-pressure).
- mult_full  in  1  mult reservation stations full (back-pressure).
- issue_valid  out  1  issue_inst is accepted by the consumer this edge.
- issue_inst  out  9  head instruction: [8:6] opcode, [5:4] rd, [3:2] rs, [1:0] rt.
- issue_unit  out  1  0 = add group, 1 = mult group.
- pc  out  clog2(PROG_DEPTH)  next fetch address.
- fifo_count  out  clog2(DEPTH)+1  FIFO occupancy.
- issued  out  CNT_W  instructions issued since start.
- running  out  1  high in RUN or DRAIN.
- halted  out  1  high in HALT.

Behaviour:
- Reset (reset_n=0 at an edge) clears pc, fifo_count, issued, running and halted to 0; state goes to IDLE; FIFO is emptied; program memory is NOT cleared.
- Reset mid-run aborts immediately; no issue_valid occurs in the reset cycle.
- Opcodes:
  - 000 ADD and 001 SUB go to unit 0.
  - 010 MUL and 011 DIV go to unit 1.
  - 111 HALT.
  - 100, 101 and 110 are NOP: fetched, dropped, never pushed.
- States:
  - IDLE: waits for start; prog_we is active.
  - start moves to RUN with pc=0, issued=0, FIFO empty.
  - RUN: fetch when fifo_count<DEPTH, sampled before any same-cycle pop. Fetch reads mem[pc] combinationally and pushes it (unless NOP/HALT); pc increments.
  - In RUN, fetching HALT, or fetching address PROG_DEPTH-1, moves to DRAIN. HALT is not pushed; the last word is pushed if not HALT/NOP. pc does not wrap; it saturates.
  - DRAIN: no fetch; issue continues; moves to HALT on the edge where the FIFO becomes empty.
  - HALT: halted=1, outputs frozen; start re-runs from pc=0, and prog_we is active.
  - start in RUN/DRAIN is ignored.
- Issue (combinational handshake, zero-latency acceptance):
  - issue_valid = running & fifo_count>0 & !(head unit full).
  - The consumer captures the head on the same edge the head is popped and issued is incremented.
  - issue_inst and issue_unit always show the head when non-empty, and 0 when empty.
  - issue_valid never depends on prog_we or start.
- Strictly in-order: a head blocked by its unit's full flag blocks all younger entries, even if they target the other unit.
- No bypass: the earliest issue of an instruction is the cycle after its fetch edge.
- Push and pop in the same cycle (not full) both occur, leaving fifo_count unchanged.
- When full, no fetch happens even if a pop occurs that cycle.
- issued saturates at all-ones.
- A prog_we during RUN/DRAIN is ignored.

Decomposition:
- tomasulo_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV and OP_HALT;
  - instruction field bit positions;
  - unit select constants UNIT_ADD=0 and UNIT_MUL=1;
  - the 9-bit instruction width.
- One sub-module, instr_rom: PROG_DEPTH x 9 register array with a synchronous write port and asynchronous read. FIFO and FSM stay in instr_issue_queue.

Test Plan:
- Load [ADD r1,r2,r3=0x01B, MUL r0,r1,r2=0x086, HALT=0x1C0], pulse start, full flags low -> issue_valid one cycle after each fetch; issues 0x01B (unit 0) then 0x086 (unit 1); issued=2, halted=1, pc=3.
- Same program, add_full=1 for the first 5 cycles after start -> no issue while high; FIFO holds 2 and MUL waits behind ADD; both issue in order after release.
- Program of six ADDs then HALT, add_full=1 throughout -> fifo_count saturates at 4 and pc stops at 4; releasing add_full drains all six, then halted=1.
- Program containing NOP 0x100 between two SUBs -> only the two SUBs issue; issued=2.
- No HALT in a 16-word program -> DRAIN entered after address 15; pc=15 (saturated) and does not wrap.
- reset_n=0 mid-RUN with FIFO holding 3 -> next cycle fifo_count=0, pc=0, issue_valid=0, state IDLE; program memory intact, and a rerun reproduces the same issue sequence.
